oversampler_phase_ctrl: RTL and testbench

Phase-selection controller for one `oversampler` instance built with `PHASE_SEL_MANUAL=1`. It drives that instance's `phase_sel_in` and scans all four sample phases. For each phase it counts `phase_err` over a fixed dwell, then commits to the lowest-error phase. While locked it watches the error rate and rescans when too many errors land inside a monitoring window.

---
 rtl/oversampler_phase_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_oversampler_phase_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oversampler_phase_ctrl.sv
// -----------------------------------------------------------------------------
// oversampler_phase_ctrl
//
// Phase-selection controller for one oversampler instance running with manual
// phase selection. It scans the four sample phases, counting phase_err over a
// fixed dwell per phase. It then commits to the lowest-error phase if that
// phase is clean enough. While locked it monitors the error rate over a sliding
// sequence of fixed windows and rescans when a window collects too many errors.
//
// Ports:
//   clock         in   oversampler fastclock domain
//   reset         in   asynchronous, active-high
//   enable        in   run the controller; low returns it to IDLE
//   phase_err     in   error flag from the oversampler
//   phase_sel_out out  [1:0] registered phase select to the oversampler
//   locked        out  high while in LOCKED
//   best_phase    out  [1:0] phase committed by the last successful scan
//   scan_done     out  one-cycle pulse after every scan, pass or fail
//   scan_fail     out  one-cycle pulse with scan_done when no phase qualified
//   relock_cnt    out  [7:0] saturating count of lock losses
//   err_cnt_flat  out  [4*CNT_W-1:0] per-phase counts of the last scan,
//                      phase n at [n*CNT_W +: CNT_W]
//
// Build option:
//   OVERSAMPLER_PHASE_CTRL_ERRCNT_EN  defined   : the four per-phase counts are
//                                                 stored and driven onto
//                                                 err_cnt_flat.
//                                     undefined : err_cnt_flat is zero and the
//                                                 winner is tracked as a running
//                                                 minimum during the scan.
// -----------------------------------------------------------------------------
module oversampler_phase_ctrl #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int SCAN_CYCLES    = 1024,
  parameter int ERR_THRESH     = 0,
  parameter int LOCK_WINDOW    = 65536,
  parameter int LOCK_ERR_LIMIT = 16,
  parameter int CNT_W          = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               phase_err,
  output logic [1:0]         phase_sel_out,
  output logic               locked,
  output logic [1:0]         best_phase,
  output logic               scan_done,
  output logic               scan_fail,
  output logic [7:0]         relock_cnt,
  output logic [4*CNT_W-1:0] err_cnt_flat
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_DWELL,
    S_EVAL,
    S_PICK,
    S_LOCK_SETTLE,
    S_LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST   = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'(LOCK_WINDOW - 1);
  localparam logic [CNT_W-1:0] THRESH      = CNT_W'(ERR_THRESH);
  localparam logic [CNT_W-1:0] ERR_LIMIT   = CNT_W'(LOCK_ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t            state_q, state_d;

  // One timer serves settle, dwell and the lock monitoring window, since only
  // one of them is ever running.
  logic [CNT_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [1:0]        idx_q, idx_d;

  logic [1:0]        sel_d;
  logic              locked_d;
  logic [1:0]        best_d;
  logic              done_d;
  logic              fail_d;
  logic [7:0]        relock_d;
  logic              eval_we;

  logic [CNT_W-1:0]  err_plus;
  logic [CNT_W-1:0]  lock_err;
  logic              win_wrap;
  logic              lock_lost;

  logic [CNT_W-1:0]  win_cnt;
  logic [1:0]        win_idx;

  // Saturating increment of the error counter by the current error flag.
  assign err_plus = (phase_err && (err_q != CNT_MAX)) ? err_q + 1'b1 : err_q;

  // On the window wrap cycle the old window is discarded and the error seen in
  // that cycle opens the new window.
  assign win_wrap  = (tmr_q == WIN_LAST);
  assign lock_err  = win_wrap ? {{(CNT_W-1){1'b0}}, phase_err} : err_plus;
  assign lock_lost = (lock_err >= ERR_LIMIT);

`ifdef OVERSAMPLER_PHASE_CTRL_ERRCNT_EN
  logic [CNT_W-1:0] stored [4];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) stored[i] <= '0;
    end else if (eval_we) begin
      stored[idx_q] <= err_q;
    end
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    win_cnt = stored[0];
    win_idx = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (stored[i] < win_cnt) begin
        win_cnt = stored[i];
        win_idx = 2'(i);
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_flat
    assign err_cnt_flat[g*CNT_W +: CNT_W] = stored[g];
  end
`else
  logic [CNT_W-1:0] min_q;
  logic [1:0]       min_idx_q;

  // Phase 0 always seeds the minimum; later phases replace it only when
  // strictly better, so ties resolve to the lowest index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_q     <= '0;
      min_idx_q <= '0;
    end else if (eval_we && ((idx_q == 2'd0) || (err_q < min_q))) begin
      min_q     <= err_q;
      min_idx_q <= idx_q;
    end
  end

  assign win_cnt      = min_q;
  assign win_idx      = min_idx_q;
  assign err_cnt_flat = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    idx_d    = idx_q;
    sel_d    = phase_sel_out;
    locked_d = locked;
    best_d   = best_phase;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    relock_d = relock_cnt;
    eval_we  = 1'b0;

    // Dropping enable wins over every other event, including a lock loss in
    // the same cycle; phase_sel_out is left where it is.
    if (!enable) begin
      state_d  = S_IDLE;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_SETTLE;
          sel_d   = 2'd0;
          idx_d   = 2'd0;
          tmr_d   = '0;
        end

        S_SETTLE: begin
          if (tmr_q == SETTLE_LAST) begin
            state_d = S_DWELL;
            tmr_d   = '0;
            err_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end

        S_DWELL: begin
          err_d = err_plus;
          if (tmr_q == SCAN_LAST) begin
            state_d = S_EVAL;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end

        S_EVAL: begin
          eval_we = 1'b1;
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            sel_d   = idx_q + 2'd1;
            tmr_d   = '0;
            state_d = S_SETTLE;
          end else begin
            state_d = S_PICK;
          end
        end

        S_PICK: begin
          done_d = 1'b1;
          tmr_d  = '0;
          if (win_cnt <= THRESH) begin
            best_d  = win_idx;
            sel_d   = win_idx;
            state_d = S_LOCK_SETTLE;
          end else begin
            fail_d  = 1'b1;
            sel_d   = 2'd0;
            idx_d   = 2'd0;
            state_d = S_SETTLE;
          end
        end

        S_LOCK_SETTLE: begin
          if (tmr_q == SETTLE_LAST) begin
            state_d  = S_LOCKED;
            locked_d = 1'b1;
            tmr_d    = '0;
            err_d    = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end

        S_LOCKED: begin
          err_d = lock_err;
          tmr_d = win_wrap ? '0 : tmr_q + 1'b1;
          if (lock_lost) begin
            state_d  = S_SETTLE;
            sel_d    = 2'd0;
            idx_d    = 2'd0;
            tmr_d    = '0;
            locked_d = 1'b0;
            relock_d = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;
          end
        end

        default: begin
          state_d  = S_IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr_q         <= '0;
      err_q         <= '0;
      idx_q         <= '0;
      phase_sel_out <= '0;
      locked        <= 1'b0;
      best_phase    <= '0;
      scan_done     <= 1'b0;
      scan_fail     <= 1'b0;
      relock_cnt    <= '0;
    end else begin
      tmr_q         <= tmr_d;
      err_q         <= err_d;
      idx_q         <= idx_d;
      phase_sel_out <= sel_d;
      locked        <= locked_d;
      best_phase    <= best_d;
      scan_done     <= done_d;
      scan_fail     <= fail_d;
      relock_cnt    <= relock_d;
    end
  end

endmodule

// File: tb/tb_oversampler_phase_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for oversampler_phase_ctrl. A timeline model (scan position derived
// from a cycle count, window errors counted per LOCK_WINDOW span) predicts the
// outputs; every cycle the DUT is compared against it at the falling edge, and
// directed scenarios add hand-computed literal checks.
// -----------------------------------------------------------------------------
module tb_oversampler_phase_ctrl;

  localparam int ST  = 4;
  localparam int SC  = 16;
  localparam int WIN = 64;
  localparam int LIM = 4;
  localparam int CW  = 16;
  localparam int PH  = ST + SC + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          phase_err = 1'b0;
  logic [1:0]    phase_sel_out;
  logic          locked;
  logic [1:0]    best_phase;
  logic          scan_done;
  logic          scan_fail;
  logic [7:0]    relock_cnt;
  logic [4*CW-1:0] err_cnt_flat;

  oversampler_phase_ctrl #(
    .SETTLE_CYCLES (ST),
    .SCAN_CYCLES   (SC),
    .ERR_THRESH    (0),
    .LOCK_WINDOW   (WIN),
    .LOCK_ERR_LIMIT(LIM),
    .CNT_W         (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .phase_err    (phase_err),
    .phase_sel_out(phase_sel_out),
    .locked       (locked),
    .best_phase   (best_phase),
    .scan_done    (scan_done),
    .scan_fail    (scan_fail),
    .relock_cnt   (relock_cnt),
    .err_cnt_flat (err_cnt_flat)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int pe_mode  = 0;  // 0 zero, 1 one, 2 one unless phase 2, 3 manual, 4 follow locked
  bit cmp_on   = 1'b0;

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 scanning, 2 lock settle, 3 locked.
  int         m_mode   = 0;
  int         m_t      = 0;
  int         m_acc    = 0;
  int         m_werr   = 0;
  int         m_cnt [4] = '{0, 0, 0, 0};
  int         mp, moff, mbi;
  logic [1:0] e_sel    = 2'd0;
  logic [1:0] e_best   = 2'd0;
  logic       e_locked = 1'b0;
  logic       e_done   = 1'b0;
  logic       e_fail   = 1'b0;
  int         e_relock = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_t = 0; m_acc = 0; m_werr = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      e_sel = 0; e_best = 0; e_locked = 0; e_done = 0; e_fail = 0; e_relock = 0;
    end else begin
      e_done = 0;
      e_fail = 0;
      if (!enable) begin
        m_mode   = 0;
        e_locked = 0;
      end else begin
        case (m_mode)
          0: begin
            m_mode = 1; m_t = 0; m_acc = 0; e_sel = 0;
          end
          1: begin
            if (m_t == 4 * PH) begin
              mbi = 0;
              for (int i = 1; i < 4; i++) if (m_cnt[i] < m_cnt[mbi]) mbi = i;
              e_done = 1;
              if (m_cnt[mbi] <= 0) begin
                e_best = 2'(mbi); e_sel = 2'(mbi); m_mode = 2;
              end else begin
                e_fail = 1; e_sel = 0;
              end
              m_t = 0; m_acc = 0;
            end else begin
              mp   = m_t / PH;
              moff = m_t % PH;
              if (moff >= ST && moff < ST + SC) m_acc += int'(phase_err);
              if (moff == PH - 1) begin
                m_cnt[mp] = m_acc;
                m_acc = 0;
                if (mp < 3) e_sel = 2'(mp + 1);
              end
              m_t++;
            end
          end
          2: begin
            if (m_t == ST - 1) begin
              m_mode = 3; e_locked = 1; m_t = 0; m_werr = 0;
            end else m_t++;
          end
          default: begin
            if (m_t % WIN == WIN - 1) m_werr = int'(phase_err);
            else                      m_werr += int'(phase_err);
            if (m_werr >= LIM) begin
              m_mode = 1; m_t = 0; m_acc = 0; e_sel = 0; e_locked = 0;
              if (e_relock < 255) e_relock++;
            end else m_t++;
          end
        endcase
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic cmp_model();
    logic [4*CW-1:0] e_flat;
`ifdef OVERSAMPLER_PHASE_CTRL_ERRCNT_EN
    e_flat = {CW'(m_cnt[3]), CW'(m_cnt[2]), CW'(m_cnt[1]), CW'(m_cnt[0])};
`else
    e_flat = '0;
`endif
    check("model_sel",    64'(phase_sel_out), 64'(e_sel));
    check("model_locked", 64'(locked),        64'(e_locked));
    check("model_best",   64'(best_phase),    64'(e_best));
    check("model_done",   64'(scan_done),     64'(e_done));
    check("model_fail",   64'(scan_fail),     64'(e_fail));
    check("model_relock", 64'(relock_cnt),    64'(e_relock));
    check("model_flat",   64'(err_cnt_flat),  64'(e_flat));
  endtask

  // One cycle: compare at the falling edge, then drive phase_err for the next edge.
  task automatic tick();
    @(negedge clock);
    if (cmp_on) cmp_model();
    case (pe_mode)
      0: phase_err = 1'b0;
      1: phase_err = 1'b1;
      2: phase_err = (phase_sel_out != 2'd2);
      4: phase_err = locked;
      default: ;
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sel"},    64'(phase_sel_out), 64'd0);
    check({tag, "_locked"}, 64'(locked),        64'd0);
    check({tag, "_best"},   64'(best_phase),    64'd0);
    check({tag, "_done"},   64'(scan_done),     64'd0);
    check({tag, "_fail"},   64'(scan_fail),     64'd0);
    check({tag, "_relock"}, 64'(relock_cnt),    64'd0);
    check({tag, "_flat"},   64'(err_cnt_flat),  64'd0);
  endtask

  // Starts from IDLE with enable low; phase_err kept at 0.
  task automatic lock_latency(input string tag);
    int done_n = 0;
    int fail_n = 0;
    pe_mode = 0;
    tick();
    enable = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      tick();
      if (scan_done) done_n++;
      if (scan_fail) fail_n++;
      if (i == 86) check({tag, "_done_at_86"}, 64'(scan_done), 64'd1);
      if (i == 89) check({tag, "_locked_at_89"}, 64'(locked), 64'd0);
      if (i == 90) check({tag, "_locked_at_90"}, 64'(locked), 64'd1);
    end
    check({tag, "_done_pulses"}, 64'(done_n), 64'd1);
    check({tag, "_fail_pulses"}, 64'(fail_n), 64'd0);
    check({tag, "_best"}, 64'(best_phase), 64'd0);
  endtask

  initial begin
    int cnt_a, cnt_b, lost, losses;
    logic prev_locked;
    logic [63:0] exp_flat;

    run(2);
    check_reset_vals("reset");
    reset = 1'b0;
    cmp_on = 1'b1;
    tick();

    // A: clean inputs, lock latency
    lock_latency("clean");

    // B: phase 2 is the only error-free phase
    enable = 1'b0;
    tick();
    pe_mode = 2;
    enable = 1'b1;
    run(100);
    check("p2_best",   64'(best_phase),    64'd2);
    check("p2_sel",    64'(phase_sel_out), 64'd2);
    check("p2_locked", 64'(locked),        64'd1);
`ifdef OVERSAMPLER_PHASE_CTRL_ERRCNT_EN
    exp_flat = 64'h0010_0000_0010_0010;
`else
    exp_flat = 64'h0;
`endif
    check("p2_flat", 64'(err_cnt_flat), exp_flat);

    // C: every phase erroneous -> scan fails and restarts
    enable = 1'b0;
    tick();
    pe_mode = 1;
    enable = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (scan_fail) cnt_a++;
      if (locked) cnt_b++;
      if (i == 86) begin
        check("fail_pulse_at_86", 64'(scan_fail), 64'd1);
        check("fail_done_at_86",  64'(scan_done), 64'd1);
        check("fail_sel_at_86",   64'(phase_sel_out), 64'd0);
      end
    end
    check("fail_pulses", 64'(cnt_a), 64'd1);
    check("fail_locked_cycles", 64'(cnt_b), 64'd0);

    // D: lock loss after LIM errors inside one window
    enable = 1'b0;
    tick();
    pe_mode = 0;
    enable = 1'b1;
    run(90);
    check("loss_pre_locked", 64'(locked), 64'd1);
    pe_mode = 3;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) check("loss_locked_before_4th", 64'(locked), 64'd1);
      phase_err = 1'b1;
      tick();
      phase_err = 1'b0;
      if (k < 3) tick();
    end
    check("loss_locked", 64'(locked),        64'd0);
    check("loss_relock", 64'(relock_cnt),    64'd1);
    check("loss_sel",    64'(phase_sel_out), 64'd0);
    run(100);
    check("relock_locked", 64'(locked), 64'd1);
    // Pulses 22 cycles apart never put more than 3 into any 64-cycle window.
    lost = 0;
    for (int j = 0; j < 300; j++) begin
      phase_err = (j % 22 == 0);
      tick();
      if (!locked) lost++;
    end
    check("three_per_window_lost", 64'(lost), 64'd0);
    check("three_per_window_relock", 64'(relock_cnt), 64'd1);
    // Disable coinciding with the limit-reaching error: no relock increment.
    phase_err = 1'b0;
    run(130);
    for (int k = 0; k < 3; k++) begin
      phase_err = 1'b1;
      tick();
    end
    enable = 1'b0;
    tick();
    phase_err = 1'b0;
    check("disable_vs_loss_locked", 64'(locked),     64'd0);
    check("disable_vs_loss_relock", 64'(relock_cnt), 64'd1);

    // E: abort mid-dwell, then a full fresh scan
    pe_mode = 0;
    tick();
    enable = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (scan_done) cnt_a++;
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (scan_done) cnt_a++;
    end
    check("abort_done_pulses", 64'(cnt_a), 64'd0);
    check("abort_locked", 64'(locked), 64'd0);
    lock_latency("rescan");

    // Asynchronous reset while locked
    reset = 1'b1;
    #1;
    check_reset_vals("async_reset");
    run(2);
    reset = 1'b0;

    // F: repeated lock losses saturate relock_cnt
    pe_mode = 4;
    losses = 0;
    prev_locked = locked;
    for (int c = 0; c < 40000 && losses < 300; c++) begin
      tick();
      if (prev_locked && !locked) losses++;
      prev_locked = locked;
    end
    check("sat_losses_seen", 64'(losses), 64'd300);
    check("sat_relock", 64'(relock_cnt), 64'd255);

    pe_mode = 0;
    enable = 1'b0;
    run(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
